gate_range_ctrl: RTL and testbench
==================================

# gate_range_ctrl

Measurement sequencer and auto-ranger for the frequency/period meter. It generates the counting window `Enable` and waits for the store/clear handshake (`Status_Value`) to finish. It then picks the next range (`F_sel` in frequency mode, `T_sel` in period mode) from the overflow (`OF`) and under-range (`UR`) flags of the finished gate. It drives the store/clear controller and the counter datapath directly; the `unable` flags tell the store/clear controller to drop gates taken right after a range or mode change.

## Interface
- `GATE_LEN`, 50000000: `Enable` high time in `CLK_50` cycles (1 s).
- `WAIT_MAX`, 10000000: maximum `CLK_50` cycles spent in WAIT before forcing DECIDE.
- `UR_HYST`, 2: number of consecutive under-range gates required before stepping down one range.
- `CLK_50` in 1: system clock; all logic is on its rising edge.
- `nRST` in 1: reset, asynchronous and active-low.
- `measure_mode` in 1: 0 = frequency, 1 = period.
- `auto_range` in 1: 1 = auto-ranging; 0 = range taken from `man_sel`.
- `man_sel` in 2: manual range code.
- `OF` in 1: counter overflow; level, may pulse.
- `UR` in 1: count below resolution threshold; valid at `Enable` fall.
- `Status_Value` in 2: store/clear status; 2'b11 means idle/cleared.
- `Enable` out 1: counting window.
- `F_sel` out 2: frequency range; 2'b11 is the largest range.
- `T_sel` out 2: period range; 2'b00 is the largest range.
- `unable` out 5: [0] discard next gate; [1] over-range at the largest range; [2] under-range at the smallest range; [4:3] are 0.

## Operation
- States: IDLE → GATE → WAIT → DECIDE → IDLE.
- IDLE: `Enable`=0. Move to GATE after `Status_Value`==2'b11 has been seen on 2 consecutive cycles.
- GATE: `Enable`=1 for exactly `GATE_LEN` cycles, timed by a 26-bit counter. `OF` is ORed into sticky `of_seen`, which is cleared on GATE entry. `UR` is sampled into `ur_seen` on the last GATE cycle.
- Mode abort in GATE: if `measure_mode` differs from its latched copy `mode_q`, `Enable` drops on the next cycle, `abort` is set, and the state goes to WAIT.
- WAIT: `Enable`=0.
  - Set `left` when `Status_Value`!=2'b11.
  - Go to DECIDE when `left` is set and `Status_Value`==2'b11, or when the wait counter reaches `WAIT_MAX`-1. The timeout covers discarded gates, where the status never leaves 2'b11.
- DECIDE lasts one cycle and updates the range. Manual mode (`auto_range`=0):
  - Load `man_sel` into the select of the current mode.
  - `changed` = (new value != old value).
  - `ur_cnt` := 0.
- DECIDE, auto mode, active select = `F_sel` (freq) or `T_sel` (period); "up" means a larger range (`F_sel`+1, or `T_sel`-1):
  - If `of_seen`: step up, `ur_cnt`:=0. If already at the largest range, the select is unchanged and `unable[1]`:=1.
  - Else if `ur_seen`: `ur_cnt`+1. When the count reaches `UR_HYST`, step down and `ur_cnt`:=0. If already at the smallest range, the select is unchanged and `unable[2]`:=1.
  - Else: `ur_cnt`:=0.
  - `OF` takes priority over `UR`.
  - `unable[1]` and `unable[2]` are rewritten at every DECIDE; they clear when their condition is absent.
- DECIDE, mode abort or mode change: `mode_q`:=`measure_mode`, both selects are held, `ur_cnt`:=0, and `changed` is forced to 1.
- `unable[0]` := `changed` at each DECIDE. A gate after a change is therefore discarded, and the next DECIDE clears the flag if nothing changed.
- The inactive-mode select never changes in auto mode.

## Timing
- Reset values:
  - `Enable`=0, `F_sel`=2'b00, `T_sel`=2'b11, `unable`=5'b00001.
  - State IDLE; `ur_cnt`=0, `mode_q`=0, `of_seen`=`ur_seen`=`left`=`abort`=0.
  - Because `unable[0]` resets to 1, the first gate is always discarded.
- `F_sel`, `T_sel` and `unable` change only in DECIDE, so they are stable at least 2 cycles before the next `Enable` rise (IDLE minimum). The store/clear controller samples them cleanly at `posedge Enable`.
- `Enable` is registered: it rises on the cycle after the IDLE→GATE transition and stays high `GATE_LEN` cycles, or fewer on abort.
- Minimum period with `Status_Value` stuck at 11: `GATE_LEN` + `WAIT_MAX` + 1 + 2 cycles.
- `OF` asserted in the same cycle as the GATE→WAIT transition is still captured; `OF` during WAIT is ignored.
- Reset mid-gate: `Enable` falls asynchronously and all state returns to reset values.
- Range selects saturate; no wrap-around.

## Test plan
- Reset, auto, freq mode, `GATE_LEN`=10, `WAIT_MAX`=20, status model returning 11 after 8 cycles → `Enable` high exactly 10 cycles; `unable[0]`=1 on the first gate and 0 from the second onward; `F_sel` stays 00.
- `OF` pulsed during gates with `F_sel`=00 → `F_sel` goes 01, 10, 11 with `unable[0]`=1 after each step. A further `OF` gives `F_sel`=11 and `unable[1]`=1; a following clean gate clears `unable[1]`.
- Period mode, `T_sel`=01, `UR` on one gate → no change. `UR` on 2 consecutive gates → `T_sel`=10. `UR` interleaved with a clean gate → `ur_cnt` resets and no step occurs.
- `OF` and `UR` on the same gate at `F_sel`=01 → `F_sel`=10 (OF wins) and `ur_cnt`=0.
- `measure_mode` toggled mid-gate → `Enable` falls on the next cycle; selects are held; `unable[0]`=1 on the next gate.
- `Status_Value` held at 11 throughout → DECIDE reached after `WAIT_MAX` cycles. Separately, `nRST` pulsed mid-gate → `Enable`=0 immediately and outputs return to reset values.

Source files
------------

// File: rtl/gate_range_ctrl_if.sv
// Bus between the gate/range sequencer and the store/clear controller and
// counter datapath. The sequencer side is "master", the environment "slave".
interface gate_range_ctrl_if;
   logic       measure_mode;
   logic       auto_range;
   logic [1:0] man_sel;
   logic       OF;
   logic       UR;
   logic [1:0] Status_Value;
   logic       Enable;
   logic [1:0] F_sel;
   logic [1:0] T_sel;
   logic [4:0] unable;

   modport master (
      input  measure_mode, auto_range, man_sel, OF, UR, Status_Value,
      output Enable, F_sel, T_sel, unable
   );

   modport slave (
      output measure_mode, auto_range, man_sel, OF, UR, Status_Value,
      input  Enable, F_sel, T_sel, unable
   );
endinterface

// File: rtl/gate_range_ctrl.sv
// Measurement sequencer and auto-ranger: generates the counting window,
// waits for the store/clear handshake, then picks the next range from the
// overflow / under-range flags of the gate that just finished.
module gate_range_ctrl #(
   parameter int GATE_LEN = 50000000,
   parameter int WAIT_MAX = 10000000,
   parameter int UR_HYST  = 2
) (
   input  logic               CLK_50,
   input  logic               nRST,
   gate_range_ctrl_if.master  bus
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_GATE   = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_DECIDE = 2'd3;

   localparam logic [25:0] GATE_LAST = 26'(GATE_LEN - 1);
   localparam logic [25:0] WAIT_LAST = 26'(WAIT_MAX - 1);
   localparam int          UW        = $clog2(UR_HYST + 1);
   localparam logic [UW-1:0] UR_TGT  = UW'(UR_HYST);

   logic [1:0]    state;
   logic [25:0]   gate_cnt;
   logic [25:0]   wait_cnt;
   logic          idle_ok;
   logic          mode_q;
   logic          of_seen;
   logic          ur_seen;
   logic          left;
   logic          abort;
   logic [UW-1:0] ur_cnt;
   logic          enable_q;
   logic [1:0]    f_sel_q;
   logic [1:0]    t_sel_q;
   logic [2:0]    unable_q;

   logic          stat_idle;
   logic          mode_chg;
   logic [1:0]    f_nxt;
   logic [1:0]    t_nxt;
   logic [UW-1:0] ur_nxt;
   logic [UW-1:0] ur_inc;
   logic          chg;
   logic          ovr_top;
   logic          und_bot;

   assign stat_idle = (bus.Status_Value == 2'b11);
   assign mode_chg  = (bus.measure_mode != mode_q);

   assign bus.Enable = enable_q;
   assign bus.F_sel  = f_sel_q;
   assign bus.T_sel  = t_sel_q;
   assign bus.unable = {2'b00, unable_q};

   // Next range decision, consumed only in DECIDE. Larger range is F+1 / T-1.
   always_comb begin
      f_nxt   = f_sel_q;
      t_nxt   = t_sel_q;
      ur_nxt  = '0;
      chg     = 1'b0;
      ovr_top = 1'b0;
      und_bot = 1'b0;
      ur_inc  = ur_cnt + 1'b1;
      if (abort || mode_chg) begin
         // selects held; the next gate is measured in a new context
         chg = 1'b1;
      end else if (!bus.auto_range) begin
         if (mode_q) begin
            t_nxt = bus.man_sel;
            chg   = (bus.man_sel != t_sel_q);
         end else begin
            f_nxt = bus.man_sel;
            chg   = (bus.man_sel != f_sel_q);
         end
      end else if (of_seen) begin
         if (mode_q) begin
            if (t_sel_q == 2'b00) ovr_top = 1'b1;
            else                  t_nxt   = t_sel_q - 2'd1;
         end else begin
            if (f_sel_q == 2'b11) ovr_top = 1'b1;
            else                  f_nxt   = f_sel_q + 2'd1;
         end
         chg = !ovr_top;
      end else if (ur_seen) begin
         if (ur_inc == UR_TGT) begin
            if (mode_q) begin
               if (t_sel_q == 2'b11) und_bot = 1'b1;
               else                  t_nxt   = t_sel_q + 2'd1;
            end else begin
               if (f_sel_q == 2'b00) und_bot = 1'b1;
               else                  f_nxt   = f_sel_q - 2'd1;
            end
            chg = !und_bot;
         end else begin
            ur_nxt = ur_inc;
         end
      end
   end

   // Sequencer: IDLE -> GATE -> WAIT -> DECIDE -> IDLE
   always_ff @(posedge CLK_50 or negedge nRST) begin
      if (!nRST) begin
         state    <= S_IDLE;
         gate_cnt <= '0;
         wait_cnt <= '0;
         idle_ok  <= 1'b0;
         mode_q   <= 1'b0;
         of_seen  <= 1'b0;
         ur_seen  <= 1'b0;
         left     <= 1'b0;
         abort    <= 1'b0;
         ur_cnt   <= '0;
         enable_q <= 1'b0;
         f_sel_q  <= 2'b00;
         t_sel_q  <= 2'b11;
         unable_q <= 3'b001;
      end else begin
         case (state)
            S_IDLE: begin
               // two consecutive idle statuses before opening a gate
               if (stat_idle) begin
                  if (idle_ok) begin
                     state    <= S_GATE;
                     enable_q <= 1'b1;
                     gate_cnt <= '0;
                     of_seen  <= 1'b0;
                  end else begin
                     idle_ok <= 1'b1;
                  end
               end else begin
                  idle_ok <= 1'b0;
               end
            end
            S_GATE: begin
               of_seen <= of_seen | bus.OF;
               if (mode_chg) begin
                  enable_q <= 1'b0;
                  abort    <= 1'b1;
                  state    <= S_WAIT;
                  wait_cnt <= '0;
                  left     <= 1'b0;
               end else if (gate_cnt == GATE_LAST) begin
                  enable_q <= 1'b0;
                  ur_seen  <= bus.UR;
                  state    <= S_WAIT;
                  wait_cnt <= '0;
                  left     <= 1'b0;
               end else begin
                  gate_cnt <= gate_cnt + 26'd1;
               end
            end
            S_WAIT: begin
               // discarded gates never leave 11, so the timeout ends those
               if (!stat_idle) left <= 1'b1;
               if ((left && stat_idle) || (wait_cnt == WAIT_LAST)) state <= S_DECIDE;
               else wait_cnt <= wait_cnt + 26'd1;
            end
            default: begin
               mode_q   <= bus.measure_mode;
               f_sel_q  <= f_nxt;
               t_sel_q  <= t_nxt;
               ur_cnt   <= ur_nxt;
               unable_q <= {und_bot, ovr_top, chg};
               abort    <= 1'b0;
               idle_ok  <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_range_ctrl.sv
// Scoreboard bench for gate_range_ctrl: each gate pushes the expected
// range/flags; they are popped and compared at the next Enable rise.
module tb_gate_range_ctrl;
   localparam int GL = 10;
   localparam int WM = 20;
   localparam int UH = 2;

   logic CLK_50 = 1'b0;
   logic nRST   = 1'b0;
   always #5 CLK_50 = ~CLK_50;

   gate_range_ctrl_if gif();

   gate_range_ctrl #(.GATE_LEN(GL), .WAIT_MAX(WM), .UR_HYST(UH)) dut (
      .CLK_50 (CLK_50),
      .nRST   (nRST),
      .bus    (gif)
   );

   typedef struct {
      logic [1:0] f;
      logic [1:0] t;
      logic [4:0] un;
   } exp_t;

   exp_t       sb[$];
   int         n_chk   = 0;
   int         n_fail  = 0;
   bit         sc_en   = 1'b1;
   int         exp_low = -1;
   logic [1:0] m_f;
   logic [1:0] m_t;
   int         m_ucnt;
   bit         m_mode;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic push_exp(input logic [4:0] un);
      exp_t e;
      e.f  = m_f;
      e.t  = m_t;
      e.un = un;
      sb.push_back(e);
   endtask

   // reference model in terms of range rank (0 smallest .. 3 largest)
   task automatic model(input bit of_p, input bit ur_p, input bit tog, input bit au,
                        input logic [1:0] man);
      bit chg = 1'b0;
      bit un1 = 1'b0;
      bit un2 = 1'b0;
      int r;
      if (tog) begin
         m_mode = ~m_mode;
         m_ucnt = 0;
         chg    = 1'b1;
      end else if (!au) begin
         if (m_mode) begin chg = (m_t != man); m_t = man; end
         else        begin chg = (m_f != man); m_f = man; end
         m_ucnt = 0;
      end else begin
         r = m_mode ? 3 - int'(m_t) : int'(m_f);
         if (of_p) begin
            m_ucnt = 0;
            if (r == 3) un1 = 1'b1;
            else begin r++; chg = 1'b1; end
         end else if (ur_p) begin
            m_ucnt++;
            if (m_ucnt == UH) begin
               m_ucnt = 0;
               if (r == 0) un2 = 1'b1;
               else begin r--; chg = 1'b1; end
            end
         end else begin
            m_ucnt = 0;
         end
         if (m_mode) m_t = 2'(3 - r);
         else        m_f = 2'(r);
      end
      push_exp({2'b00, un2, un1, chg});
   endtask

   task automatic pop_chk();
      exp_t e;
      chk("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("F_sel", 32'(gif.F_sel), 32'(e.f));
         chk("T_sel", 32'(gif.T_sel), 32'(e.t));
         chk("unable", 32'(gif.unable), 32'(e.un));
      end
   endtask

   task automatic wait_rise();
      int n = 0;
      while (gif.Enable !== 1'b1 && n < 200) begin
         @(negedge CLK_50);
         n++;
      end
      chk("enable_rise", 32'(n < 200), 1);
      if (exp_low >= 0) begin
         chk("idle_low_cycles", n, exp_low);
         exp_low = -1;
      end
      pop_chk();
   endtask

   task automatic do_gate(input bit of_p, input bit ur_p, input bit tog, input bit au,
                          input logic [1:0] man);
      int hi = 0;
      wait_rise();
      gif.auto_range = au;
      gif.man_sel    = man;
      gif.UR         = ur_p;
      while (gif.Enable === 1'b1 && hi < 100) begin
         hi++;
         gif.OF = of_p && (hi == 3);
         if (tog && hi == 4) gif.measure_mode = ~gif.measure_mode;
         @(negedge CLK_50);
      end
      gif.OF = 1'b0;
      gif.UR = 1'b0;
      chk("gate_len", hi, tog ? 4 : GL);
      model(of_p, ur_p, tog, au, man);
   endtask

   // store/clear controller model: busy for 8 cycles after each gate
   initial begin
      gif.Status_Value = 2'b11;
      forever begin
         @(negedge gif.Enable);
         if (sc_en) begin
            @(negedge CLK_50);
            gif.Status_Value = 2'b01;
            repeat (8) @(negedge CLK_50);
            gif.Status_Value = 2'b11;
         end
      end
   end

   // stimulus sequence
   initial begin
      gif.measure_mode = 1'b0;
      gif.auto_range   = 1'b1;
      gif.man_sel      = 2'b00;
      gif.OF           = 1'b0;
      gif.UR           = 1'b0;
      nRST             = 1'b0;
      repeat (3) @(negedge CLK_50);
      chk("rst_enable", 32'(gif.Enable), 0);
      chk("rst_F_sel", 32'(gif.F_sel), 0);
      chk("rst_T_sel", 32'(gif.T_sel), 3);
      chk("rst_unable", 32'(gif.unable), 1);
      nRST   = 1'b1;
      m_f    = 2'b00;
      m_t    = 2'b11;
      m_ucnt = 0;
      m_mode = 1'b0;
      push_exp(5'b00001);

      // frequency mode: clean gates, then overflow climb and saturation
      do_gate(0, 0, 0, 1, 2'b00);
      do_gate(0, 0, 0, 1, 2'b00);
      for (int i = 0; i < 4; i++) do_gate(1, 0, 0, 1, 2'b00);
      do_gate(0, 0, 0, 1, 2'b00);
      // manual load to 01, then OF+UR together, then one UR
      do_gate(0, 0, 0, 0, 2'b01);
      do_gate(1, 1, 0, 1, 2'b00);
      do_gate(0, 1, 0, 1, 2'b00);
      // mode toggle mid-gate: freq -> period
      do_gate(0, 0, 1, 1, 2'b00);
      // period mode: manual 01, then under-range hysteresis
      do_gate(0, 0, 0, 0, 2'b01);
      do_gate(0, 1, 0, 1, 2'b00);
      do_gate(0, 0, 0, 1, 2'b00);
      for (int i = 0; i < 6; i++) do_gate(0, 1, 0, 1, 2'b00);
      do_gate(0, 0, 0, 1, 2'b00);
      do_gate(1, 0, 0, 1, 2'b00);
      // status stuck at 11: WAIT ends on timeout
      sc_en = 1'b0;
      do_gate(0, 0, 0, 1, 2'b00);
      exp_low = WM + 3;
      do_gate(0, 0, 0, 1, 2'b00);
      sc_en = 1'b1;

      // reset in the middle of a gate
      wait_rise();
      repeat (3) @(negedge CLK_50);
      #2 nRST = 1'b0;
      #1;
      chk("midrst_enable", 32'(gif.Enable), 0);
      chk("midrst_F_sel", 32'(gif.F_sel), 0);
      chk("midrst_T_sel", 32'(gif.T_sel), 3);
      chk("midrst_unable", 32'(gif.unable), 1);
      gif.measure_mode = 1'b0;
      @(negedge CLK_50);
      nRST = 1'b1;
      sb.delete();
      m_f    = 2'b00;
      m_t    = 2'b11;
      m_ucnt = 0;
      m_mode = 1'b0;
      push_exp(5'b00001);
      do_gate(0, 0, 0, 1, 2'b00);
      wait_rise();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
